// File: rtl/score_uart_pkg.sv
// rtl/score_uart_pkg.sv - shared message length, ASCII constants, sequencer states and byte mapping
package score_uart_pkg;

  localparam int MSG_LEN = 11;

  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_B     = 8'h42;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } seq_state_t;

  // BCD digit to ASCII; non-decimal codes show up as '?' on the host
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (ASCII_ZERO + {4'd0, d}) : ASCII_QMARK;
  endfunction

  // Byte idx of "A=dd B=dd\r\n"
  function automatic logic [7:0] msg_byte(input logic [3:0] idx,
                                          input logic [3:0] d1a, input logic [3:0] d0a,
                                          input logic [3:0] d1b, input logic [3:0] d0b);
    logic [7:0] b;
    case (idx)
      4'd0:    b = ASCII_A;
      4'd1:    b = ASCII_EQ;
      4'd2:    b = digit_ascii(d1a);
      4'd3:    b = digit_ascii(d0a);
      4'd4:    b = ASCII_SPACE;
      4'd5:    b = ASCII_B;
      4'd6:    b = ASCII_EQ;
      4'd7:    b = digit_ascii(d1b);
      4'd8:    b = digit_ascii(d0b);
      4'd9:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - one-byte UART serializer, 8N1 or 8E1 when SCORE_UART_TX_PARITY_EN is defined
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  output logic       ready,
  input  logic [7:0] data,
  output logic       tx,
  output logic       frame_end
);

`ifdef SCORE_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int TAIL_W     = 10;
`else
  localparam int FRAME_BITS = 10;
  localparam int TAIL_W     = 9;
`endif
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  logic              active;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        bit_n;
  logic [TAIL_W-1:0] shreg;
  logic [TAIL_W-1:0] frame_tail;

  // Bits following the start bit, LSB shifted out first
  always_comb begin
`ifdef SCORE_UART_TX_PARITY_EN
    frame_tail = {1'b1, ^data, data};
`else
    frame_tail = {1'b1, data};
`endif
  end

  // Ready again in the final cycle of the stop bit so frames chain with no gap
  assign frame_end = active && (cnt == CNT_LAST) && (bit_n == BIT_LAST);
  assign ready     = !active || frame_end;

  // Bit timing and shift register; tx is a flop so reset forces the line idle at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      cnt    <= '0;
      bit_n  <= 4'd0;
      shreg  <= '0;
      tx     <= 1'b1;
    end else if (valid && ready) begin
      active <= 1'b1;
      cnt    <= '0;
      bit_n  <= 4'd0;
      shreg  <= frame_tail;
      tx     <= 1'b0;
    end else if (active) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (bit_n == BIT_LAST) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_n <= bit_n + 4'd1;
          tx    <= shreg[0];
          shreg <= shreg >> 1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/score_uart_tx.sv
// rtl/score_uart_tx.sv - score message sequencer over uart_tx_byte; SCORE_UART_TX_PARITY_EN adds even parity
module score_uart_tx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [3:0] dig1_A,
  input  logic [3:0] dig0_A,
  input  logic [3:0] dig1_B,
  input  logic [3:0] dig0_B,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  import score_uart_pkg::*;

  localparam logic [3:0] IDX_LAST = 4'(MSG_LEN - 1);

  seq_state_t state, next_state;
  logic [3:0] idx;
  logic [3:0] snap_d1a, snap_d0a, snap_d1b, snap_d0b;
  logic       accept;
  logic       byte_valid, byte_ready, byte_frame_end;
  logic [7:0] byte_data;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk       (clk),
    .reset     (reset),
    .valid     (byte_valid),
    .ready     (byte_ready),
    .data      (byte_data),
    .tx        (tx),
    .frame_end (byte_frame_end)
  );

  // Sequencer state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and byte feed; byte 0 goes out on acceptance so the start bit lines up with busy
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (send && byte_ready) begin
          accept     = 1'b1;
          byte_valid = 1'b1;
          byte_data  = msg_byte(4'd0, dig1_A, dig0_A, dig1_B, dig0_B);
          next_state = LOAD;
        end
      end
      LOAD: next_state = SHIFT;
      SHIFT: begin
        if (idx != IDX_LAST) begin
          byte_valid = 1'b1;
          byte_data  = msg_byte(idx + 4'd1, snap_d1a, snap_d0a, snap_d1b, snap_d0b);
        end else if (byte_frame_end) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Byte index: cleared in LOAD, advanced per handshake, never past the last byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      idx <= 4'd0;
    else if (state == LOAD)                         idx <= 4'd0;
    else if (state == SHIFT && byte_valid && byte_ready) idx <= idx + 4'd1;
  end

  // Digit snapshot so input changes cannot corrupt a message in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_d1a <= 4'd0;
      snap_d0a <= 4'd0;
      snap_d1b <= 4'd0;
      snap_d0b <= 4'd0;
    end else if (accept) begin
      snap_d1a <= dig1_A;
      snap_d0a <= dig0_A;
      snap_d1b <= dig1_B;
      snap_d0b <= dig0_B;
    end
  end

  // Completion pulse lands in the cycle the sequencer is back in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= (state == SHIFT) && (idx == IDX_LAST) && byte_frame_end;
  end

endmodule

// File: tb/tb_score_uart_tx.sv
// tb/tb_score_uart_tx.sv - directed bench for score_uart_tx with CLKS_PER_BIT=4
module tb_score_uart_tx;

  localparam int CPB = 4;
`ifdef SCORE_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int MSG_CYC = 11 * FB * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [3:0] dig1_A = 4'd0, dig0_A = 4'd0, dig1_B = 4'd0, dig0_B = 4'd0;
  logic       tx, busy, done;

  score_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .reset  (reset),
    .send   (send),
    .dig1_A (dig1_A),
    .dig0_A (dig0_A),
    .dig1_B (dig1_B),
    .dig0_B (dig0_B),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d1a, d0a, d1b, d0b;
    logic [7:0] e1a, e0a, e1b, e0b;
  } vec_t;

  vec_t       vecs [4];
  int         total = 0;
  int         bad = 0;
  logic       samp [MSG_CYC];
  logic [7:0] exp_msg [11];
  int         busy_gap;
  int         done_cnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic apply_digits(input int v);
    dig1_A = vecs[v].d1a; dig0_A = vecs[v].d0a;
    dig1_B = vecs[v].d1b; dig0_B = vecs[v].d0b;
    exp_msg[0] = 8'h41; exp_msg[1] = 8'h3D;
    exp_msg[2] = vecs[v].e1a; exp_msg[3] = vecs[v].e0a;
    exp_msg[4] = 8'h20; exp_msg[5] = 8'h42; exp_msg[6] = 8'h3D;
    exp_msg[7] = vecs[v].e1b; exp_msg[8] = vecs[v].e0b;
    exp_msg[9] = 8'h0D; exp_msg[10] = 8'h0A;
  endtask

  // Pulse send; returns at the negedge of message cycle 0
  task automatic start_msg();
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  // Record tx for a whole message; optionally retry send with new digits mid-message
  task automatic capture(input string name, input int resend_at);
    busy_gap = 0;
    done_cnt = 0;
    for (int k = 0; k < MSG_CYC; k++) begin
      if (k > 0) @(negedge clk);
      samp[k] = tx;
      if (!busy) busy_gap++;
      if (done) done_cnt++;
      if (k == resend_at) begin
        dig1_A = 4'd9; dig0_A = 4'd9; dig1_B = 4'd9; dig0_B = 4'd9;
        send = 1'b1;
      end
      if (k == resend_at + 1) send = 1'b0;
    end
    check({name, "_busy_gap"}, busy_gap, 0);
    check({name, "_early_done"}, done_cnt, 0);
    @(negedge clk);
    check({name, "_done_end"}, {31'd0, done}, 1);
    check({name, "_busy_end"}, {31'd0, busy}, 0);
  endtask

  // Decode each frame and compare every sample against the ideal waveform
  task automatic check_msg(input string name);
    for (int b = 0; b < 11; b++) begin
      logic [7:0] got;
      int         wave_err;
      got = 8'h00;
      wave_err = 0;
      for (int j = 0; j < FB; j++) begin
        logic want;
        if (j == 0)           want = 1'b0;
        else if (j <= 8)      want = exp_msg[b][j-1];
        else if (j == FB - 1) want = 1'b1;
        else                  want = ^exp_msg[b];
        for (int s = 0; s < CPB; s++)
          if (samp[b*FB*CPB + j*CPB + s] !== want) wave_err++;
        if (j >= 1 && j <= 8) got[j-1] = samp[b*FB*CPB + j*CPB + CPB/2];
      end
      check($sformatf("%s_byte%0d", name, b), {24'd0, got}, {24'd0, exp_msg[b]});
      check($sformatf("%s_wave%0d", name, b), wave_err, 0);
    end
  endtask

  initial begin
    int done_idx [3];
    int nd;
    int busy_low;
    int waited;

    vecs[0] = '{4'd0, 4'd7, 4'd1, 4'd2, 8'h30, 8'h37, 8'h31, 8'h32};
    vecs[1] = '{4'd9, 4'd9, 4'd0, 4'hC, 8'h39, 8'h39, 8'h30, 8'h3F};
    vecs[2] = '{4'hA, 4'hF, 4'd3, 4'd5, 8'h3F, 8'h3F, 8'h33, 8'h35};
    vecs[3] = '{4'd5, 4'd0, 4'd9, 4'd8, 8'h35, 8'h30, 8'h39, 8'h38};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven messages
    for (int v = 0; v < 4; v++) begin
      apply_digits(v);
      start_msg();
      check($sformatf("v%0d_start_tx", v), {31'd0, tx}, 0);
      check($sformatf("v%0d_start_busy", v), {31'd0, busy}, 1);
      capture($sformatf("v%0d", v), -1);
      check_msg($sformatf("v%0d", v));
      repeat (3) @(negedge clk);
    end

    // Send while busy is ignored; digits changed mid-message are not used
    apply_digits(0);
    start_msg();
    capture("ign", 100);
    check_msg("ign");
    done_cnt = 0;
    busy_low = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (!busy) busy_low++;
    end
    check("ign_extra_done", done_cnt, 0);
    check("ign_no_queue", busy_low, 30);

    // Reset mid-message aborts without a done pulse
    apply_digits(2);
    start_msg();
    repeat (57) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_tx", {31'd0, tx}, 1);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    done_cnt = 0;
    @(negedge clk);
    if (done) done_cnt++;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy || !tx) done_cnt++;
    end
    check("abort_quiet", done_cnt, 0);
    apply_digits(3);
    start_msg();
    capture("after_abort", -1);
    check_msg("after_abort");
    repeat (2) @(negedge clk);

    // send held high: back-to-back messages, one LOAD cycle apart
    apply_digits(1);
    send = 1'b1;
    @(negedge clk);
    nd = 0;
    busy_low = 0;
    for (int k = 0; k <= 3 * MSG_CYC + 2; k++) begin
      if (k > 0) @(negedge clk);
      if (done && nd < 3) begin
        done_idx[nd] = k;
        nd++;
      end
      if (!busy) busy_low++;
      if (k == MSG_CYC + 1) begin
        check("hold_restart_tx", {31'd0, tx}, 0);
        check("hold_restart_busy", {31'd0, busy}, 1);
      end
    end
    check("hold_done_count", nd, 3);
    check("hold_done0", (nd > 0) ? done_idx[0] : -1, MSG_CYC);
    check("hold_done1", (nd > 1) ? done_idx[1] : -1, 2 * MSG_CYC + 1);
    check("hold_done2", (nd > 2) ? done_idx[2] : -1, 3 * MSG_CYC + 2);
    check("hold_busy_low", busy_low, 3);
    send = 1'b0;
    waited = 0;
    while (!done && waited < MSG_CYC + 10) begin
      @(negedge clk);
      waited++;
    end
    check("hold_final_done", {31'd0, done}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/score_uart_tx.md
SCORE_UART_TX -- requirements
Module: score_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417, clk cycles per UART bit (9600 baud at 100 MHz).
REQ-002 Parameter MSG_LEN, default 11, bytes per score message; fixed, not user-overridable.
REQ-003 The clock SHALL be clk, and the reset SHALL be reset, asynchronous, active-high.
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 send  input  1  request to transmit one score message; sampled each clk.
REQ-007 dig1_A, dig0_A, dig1_B, dig0_B  input  4 each  BCD score digits (tens, ones) for players A and B.
REQ-008 tx  output  1  UART serial line to host (RsTx); idle high.
REQ-009 busy  output  1  high while a message is in progress.
REQ-010 done  output  1  one-cycle pulse when the final stop bit of a message completes.

Function
REQ-011 The message SHALL be the ASCII sequence "A=<dig1_A><dig0_A> B=<dig1_B><dig0_B>\r\n": 11 bytes, 0x41 0x3D d d 0x20 0x42 0x3D d d 0x0D 0x0A.
REQ-012 A digit value 0-9 SHALL map to 0x30+value; 10-15 SHALL map to 0x3F ('?').
REQ-013 The four digits SHALL be snapshotted on the cycle send is accepted; later input changes SHALL NOT affect the message in flight.
REQ-014 send SHALL be accepted only when busy=0; send while busy=1 SHALL be ignored and not queued.
REQ-015 busy SHALL rise on the cycle after acceptance; tx SHALL go low (start bit) on the same cycle.
REQ-016 Each frame SHALL be 8N1: start bit 0, data bits LSB first, stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-017 Frames SHALL be back-to-back with no idle gap; a message lasts exactly 11*10*CLKS_PER_BIT cycles from the first start-bit edge.
REQ-018 On completion of the last stop bit, done=1 and busy=0 in the same cycle; a send in that cycle SHALL be accepted.
REQ-019 Sequencer states SHALL be IDLE, LOAD, SHIFT; IDLE->LOAD on accepted send, LOAD->SHIFT next cycle selecting byte index 0, SHIFT->SHIFT at byte boundary while index<MSG_LEN-1, SHIFT->IDLE after byte MSG_LEN-1.
REQ-020 The byte index counter SHALL be 4 bits and SHALL NOT wrap past MSG_LEN-1; the bit-period counter SHALL be sized ceil(log2(CLKS_PER_BIT)).

Reset
REQ-021 On reset: tx=1, busy=0, done=0, state IDLE, all counters and snapshot registers 0.
REQ-022 Reset asserted mid-frame SHALL force tx=1 immediately (asynchronously), abort the message, and emit no done pulse.

Configuration
REQ-023 Macro SCORE_UART_TX_PARITY_EN defined: each frame SHALL insert an even-parity bit between data bit 7 and the stop bit (11 bits/frame, message 11*11*CLKS_PER_BIT cycles).
REQ-024 Macro SCORE_UART_TX_PARITY_EN undefined: frames SHALL be 8N1 exactly as in REQ-016/017.

Structure
REQ-025 A shared package score_uart_pkg SHALL hold MSG_LEN, the ASCII constants (0x41, 0x42, 0x3D, 0x20, 0x0D, 0x0A, 0x30, 0x3F) and the sequencer state encoding.
REQ-026 Byte serialization SHALL be a sub-module uart_tx_byte (valid/ready handshake, tx, parity per macro); score_uart_tx SHALL contain the message sequencer and the digit-to-ASCII mapping.

Verification (CLKS_PER_BIT=4 in simulation)
REQ-027 Digits A=0,7 B=1,2, pulse send -> tx decodes "A=07 B=12\r\n", done after exactly 440 cycles from the first start edge, busy high throughout.
REQ-028 dig0_B=4'hC -> byte 8 transmitted as 0x3F.
REQ-029 Change all digits to 9 and pulse send again at cycle 100 of a message -> second send ignored; the message still carries the original digits; exactly one done pulse.
REQ-030 Assert reset at cycle 57 of a message -> tx=1 in the same cycle, busy=0, no done; a new send afterwards yields a complete correct message.
REQ-031 Hold send high continuously -> messages back-to-back, every 441 cycles (one LOAD cycle each), done pulses each message.
REQ-032 With SCORE_UART_TX_PARITY_EN defined, send 'A' (0x41) -> parity bit 0, frame 44 cycles; message 484 cycles.
